// File: rtl/matseq_pkg.sv
// Shared defaults, index width and FSM states for the C = A x B operand feeder.
package matseq_pkg;

    localparam int N_DEF  = 4;
    localparam int DW_DEF = 8;
    localparam int IW_DEF = $clog2(N_DEF);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        EMIT,
        DONE
    } state_t;

endpackage

// File: rtl/matseq_regfile.sv
// A and B operand stores: one write port, two combinational read ports,
// synchronous clear.
module matseq_regfile
    import matseq_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          we,
    input  logic          sel,
    input  logic [IW-1:0] wrow,
    input  logic [IW-1:0] wcol,
    input  logic [DW-1:0] wdata,
    input  logic [IW-1:0] a_row,
    input  logic [IW-1:0] a_col,
    input  logic [IW-1:0] b_row,
    input  logic [IW-1:0] b_col,
    output logic [DW-1:0] a_data,
    output logic [DW-1:0] b_data
);

    logic [DW-1:0] a_mem [N][N];
    logic [DW-1:0] b_mem [N][N];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_mem[r][c] <= '0;
                    b_mem[r][c] <= '0;
                end
            end
        end else if (we) begin
            if (sel) b_mem[wrow][wcol] <= wdata;
            else     a_mem[wrow][wcol] <= wdata;
        end
    end

    assign a_data = a_mem[a_row][a_col];
    assign b_data = b_mem[b_row][b_col];

endmodule

// File: rtl/matseq_feeder.sv
// Sequences A x B operands into a downstream MAC, one C element at a time.
// Optional MATSEQ_TRANSPOSE_EN: tr_b latched at start selects B[j][k].
module matseq_feeder
    import matseq_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          aclr,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [IW-1:0] wr_row,
    input  logic [IW-1:0] wr_col,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    input  logic          tr_b,
    output logic          busy,
    output logic [DW-1:0] mplier,
    output logic [DW-1:0] mcand,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          res_valid,
    output logic [IW-1:0] res_row,
    output logic [IW-1:0] res_col,
    input  logic          res_ready,
    output logic          done
);

    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t        state, nstate;
    logic [IW-1:0] i, j, k;
    logic [IW-1:0] ni, nj, nk;
    logic [IW-1:0] b_row, b_col;
    logic [DW-1:0] a_rd, b_rd;

`ifdef MATSEQ_TRANSPOSE_EN
    logic tr_q, ntr;
`else
    logic unused_tr;
    assign unused_tr = tr_b;
`endif

    always_comb begin
        nstate = state;
        ni     = i;
        nj     = j;
        nk     = k;
`ifdef MATSEQ_TRANSPOSE_EN
        ntr    = tr_q;
`endif
        unique case (state)
            IDLE: begin
                if (start) begin
                    nstate = CLEAR;
                    ni     = '0;
                    nj     = '0;
                    nk     = '0;
`ifdef MATSEQ_TRANSPOSE_EN
                    ntr    = tr_b;
`endif
                end
            end
            CLEAR: begin
                nstate = ACCUM;
                nk     = '0;
            end
            ACCUM: begin
                nk = k + 1'b1;
                if (k == LAST) nstate = EMIT;
            end
            EMIT: begin
                if (res_ready) begin
                    nj = j + 1'b1;
                    if (j == LAST) ni = i + 1'b1;
                    nstate = (i == LAST && j == LAST) ? DONE : CLEAR;
                end
            end
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
`ifdef MATSEQ_TRANSPOSE_EN
            tr_q  <= 1'b0;
`endif
        end else begin
            state <= nstate;
            i     <= ni;
            j     <= nj;
            k     <= nk;
`ifdef MATSEQ_TRANSPOSE_EN
            tr_q  <= ntr;
`endif
        end
    end

    // Reads are addressed by next-cycle indices so operand registers line up
    // with the state they are shown in.
`ifdef MATSEQ_TRANSPOSE_EN
    assign b_row = ntr ? nj : nk;
    assign b_col = ntr ? nk : nj;
`else
    assign b_row = nk;
    assign b_col = nj;
`endif

    matseq_regfile #(
        .N  (N),
        .DW (DW)
    ) u_rf (
        .clk    (clk),
        .clr    (aclr),
        .we     (wr_en && state == IDLE),
        .sel    (wr_sel),
        .wrow   (wr_row),
        .wcol   (wr_col),
        .wdata  (wr_data),
        .a_row  (ni),
        .a_col  (nk),
        .b_row  (b_row),
        .b_col  (b_col),
        .a_data (a_rd),
        .b_data (b_rd)
    );

    always_ff @(posedge clk) begin
        if (aclr) begin
            busy      <= 1'b0;
            mplier    <= '0;
            mcand     <= '0;
            mac_clr   <= 1'b0;
            mac_en    <= 1'b0;
            res_valid <= 1'b0;
            res_row   <= '0;
            res_col   <= '0;
            done      <= 1'b0;
        end else begin
            busy      <= nstate != IDLE;
            mplier    <= (nstate == ACCUM) ? a_rd : '0;
            mcand     <= (nstate == ACCUM) ? b_rd : '0;
            mac_clr   <= nstate == CLEAR;
            mac_en    <= nstate == ACCUM;
            res_valid <= nstate == EMIT;
            res_row   <= (nstate == EMIT) ? ni : '0;
            res_col   <= (nstate == EMIT) ? nj : '0;
            done      <= nstate == DONE;
        end
    end

endmodule

// File: tb/tb_matseq_feeder.sv
// Scoreboard bench for matseq_feeder: operand/result queues plus a MAC model.
module tb_matseq_feeder;

    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk = 0;
    logic          aclr = 1;
    logic          wr_en = 0;
    logic          wr_sel = 0;
    logic [1:0]    wr_row = 0;
    logic [1:0]    wr_col = 0;
    logic [DW-1:0] wr_data = 0;
    logic          start = 0;
    logic          tr_b = 0;
    logic          busy;
    logic [DW-1:0] mplier;
    logic [DW-1:0] mcand;
    logic          mac_clr;
    logic          mac_en;
    logic          res_valid;
    logic [1:0]    res_row;
    logic [1:0]    res_col;
    logic          res_ready = 1;
    logic          done;

    int errors = 0;
    int checks = 0;

    int ma [N][N];
    int mb [N][N];
    int qm[$], qc[$], rq_r[$], rq_c[$], rq_v[$];

    matseq_feeder #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .aclr      (aclr),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
        .start     (start),
        .tr_b      (tr_b),
        .busy      (busy),
        .mplier    (mplier),
        .mcand     (mcand),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .res_valid (res_valid),
        .res_row   (res_row),
        .res_col   (res_col),
        .res_ready (res_ready),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wr(input bit sel, input int r, input int c, input int d);
        wr_en = 1; wr_sel = sel;
        wr_row = 2'(r); wr_col = 2'(c); wr_data = 8'(d);
        @(posedge clk); #1;
        wr_en = 0;
        if (sel) mb[r][c] = d;
        else     ma[r][c] = d;
    endtask

    task automatic run_seq(input bit tr, input int hold_elem,
                           input int disturb_at, input int exp_cyc);
        int acc, cyc, nres, nacc, hold, hr, hc, m, c;
        bit tm, in_emit;
`ifdef MATSEQ_TRANSPOSE_EN
        tm = tr;
`else
        tm = 0;
`endif
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                acc = 0;
                for (int k = 0; k < N; k++) begin
                    m = ma[i][k];
                    c = tm ? mb[j][k] : mb[k][j];
                    qm.push_back(m); qc.push_back(c);
                    acc += m * c;
                end
                rq_r.push_back(i); rq_c.push_back(j); rq_v.push_back(acc);
            end
        acc = 0; nres = 0; nacc = 0; hold = 0; in_emit = 0; hr = 0; hc = 0;
        res_ready = 1; tr_b = tr; start = 1;
        @(posedge clk); #1;
        start = 0; cyc = 1;
        chk("busy_at_start", busy, 1);
        while (!done && cyc <= 400) begin
            start = 0; wr_en = 0;
            if (mac_clr) begin
                acc = 0;
                chk("clr_no_en", mac_en, 0);
            end
            if (mac_en) begin
                nacc++;
                if (qm.size() > 0) begin
                    chk("mplier", mplier, qm.pop_front());
                    chk("mcand", mcand, qc.pop_front());
                end else chk("op_underflow", 1, 0);
                acc += int'(mplier) * int'(mcand);
                if (nacc == disturb_at) begin
                    start = 1; wr_en = 1; wr_sel = 0;
                    wr_row = 0; wr_col = 0; wr_data = 99;
                end
            end else begin
                chk("ops_zero", {mplier, mcand}, 0);
            end
            if (res_valid) begin
                if (!in_emit) begin
                    in_emit = 1;
                    hr = res_row; hc = res_col;
                    if (rq_r.size() > 0) begin
                        chk("res_row", res_row, rq_r.pop_front());
                        chk("res_col", res_col, rq_c.pop_front());
                        chk("res_val", acc, rq_v.pop_front());
                    end else chk("res_underflow", 1, 0);
                    hold = (nres == hold_elem) ? 5 : 0;
                end else begin
                    chk("hold_row", res_row, hr);
                    chk("hold_col", res_col, hc);
                    chk("hold_quiet", {mac_en, mac_clr}, 0);
                end
                if (hold > 0) begin
                    res_ready = 0; hold--;
                end else begin
                    res_ready = 1; in_emit = 0; nres++;
                end
            end else res_ready = 1;
            @(posedge clk); #1;
            cyc++;
        end
        start = 0; wr_en = 0; res_ready = 1;
        chk("done_seen", done, 1);
        chk("done_busy", busy, 1);
        chk("latency", cyc, exp_cyc);
        chk("handshakes", nres, N * N);
        chk("queues_empty", qm.size() + rq_v.size(), 0);
        qm.delete(); qc.delete();
        rq_r.delete(); rq_c.delete(); rq_v.delete();
        @(posedge clk); #1;
        chk("idle_after", {busy, done}, 0);
    endtask

    task automatic reset_mid();
        int n, cyc;
        n = 0; cyc = 0;
        tr_b = 0; start = 1;
        @(posedge clk); #1;
        start = 0;
        while (n < 3 && cyc < 50) begin
            if (mac_en) n++;
            if (n < 3) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk("mid_reach_k2", n, 3);
        aclr = 1; start = 1; wr_en = 1; wr_sel = 0;
        wr_row = 0; wr_col = 0; wr_data = 77;
        @(posedge clk); #1;
        start = 0; wr_en = 0;
        chk("mid_rst_outs", {busy, mplier, mcand, mac_clr, mac_en,
                             res_valid, res_row, res_col, done}, 0);
        aclr = 0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("no_done_after_rst", {busy, done}, 0);
        end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = 0; mb[r][c] = 0;
            end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {busy, mplier, mcand, mac_clr, mac_en,
                           res_valid, res_row, res_col, done}, 0);
        aclr = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = 0; mb[r][c] = 0;
            end

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                wr(0, r, c, (r == c) ? 1 : 0);
                wr(1, r, c, 4 * r + c + 1);
            end
        run_seq(0, -1, 0, 97);
        run_seq(0, 1, 0, 102);
        run_seq(0, -1, 6, 97);
        run_seq(0, -1, 0, 97);

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                wr(1, r, c, (r == 0 && c == 1) ? 5 : 0);
        run_seq(1, -1, 0, 97);
        run_seq(0, -1, 0, 97);

        reset_mid();
        run_seq(0, -1, 0, 97);

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                wr(0, r, c, 255);
                wr(1, r, c, 255);
            end
        run_seq(0, -1, 0, 97);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matseq_feeder.md
MATSEQ_FEEDER -- requirements
Module: matseq_feeder

Interface
REQ-001 Parameter N, default 4, matrix dimension (square N x N, N >= 2, power of two).
REQ-002 Parameter DW, default 8, operand element width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 aclr  input  1  reset, synchronous, active-high.
REQ-005 wr_en  input  1  operand-store write strobe.
REQ-006 wr_sel  input  1  0 = matrix A, 1 = matrix B.
REQ-007 wr_row, wr_col  input  log2(N) each  write address.
REQ-008 wr_data  input  DW  element value.
REQ-009 start  input  1  begin full C = A x B sequence.
REQ-010 tr_b  input  1  B-transpose request, sampled at accepted start.
REQ-011 busy  output  1  high from accepted start until done cycle inclusive.
REQ-012 mplier, mcand  output  DW each  operands to the downstream MAC.
REQ-013 mac_clr  output  1  one-cycle accumulator clear to the MAC.
REQ-014 mac_en  output  1  operands valid, accumulate this cycle.
REQ-015 res_valid  output  1  MAC output holds C[res_row][res_col].
REQ-016 res_row, res_col  output  log2(N) each  index of the current result.
REQ-017 res_ready  input  1  consumer has taken the result.
REQ-018 done  output  1  one-cycle pulse after the last result is accepted.

Function
REQ-019 FSM states SHALL be IDLE, CLEAR, ACCUM, EMIT, DONE; all outputs registered.
REQ-020 Writes SHALL take effect only in IDLE; writes in any other state are dropped.
REQ-021 start in IDLE SHALL move to CLEAR next cycle with i=j=k=0; start outside IDLE is ignored.
REQ-022 CLEAR: mac_clr=1, mac_en=0, exactly one cycle, then ACCUM.
REQ-023 ACCUM: N consecutive cycles, mac_en=1, mplier=A[i][k], mcand=B[k][j], k = 0..N-1; then EMIT.
REQ-024 Outside ACCUM, mac_en=0 and mplier=mcand=0.
REQ-025 EMIT: res_valid=1, res_row=i, res_col=j, held stable until res_ready=1 is sampled.
REQ-026 EMIT with res_ready=1 SHALL advance (i,j) row-major and go to CLEAR; after (N-1,N-1), go to DONE.
REQ-027 res_ready outside EMIT SHALL be ignored.
REQ-028 DONE: done=1 for one cycle, then IDLE; busy deasserts in the cycle after DONE.
REQ-029 With res_ready tied high, per-element cost is N+2 cycles; full matrix N*N*(N+2)+1 cycles from accepted start to done.
REQ-030 Index counters SHALL wrap modulo N with no overflow flag; k, i, j are log2(N) bits wide.

Reset
REQ-031 aclr=1 SHALL, at the next edge, force IDLE, zero all counters, and zero both operand stores.
REQ-032 While aclr=1, every output SHALL be 0: busy, mplier, mcand, mac_clr, mac_en, res_valid, res_row, res_col, done.
REQ-033 aclr SHALL override start, wr_en and res_ready in the same cycle; reset mid-sequence abandons it, with no done pulse.

Configuration
REQ-034 Macro MATSEQ_TRANSPOSE_EN defined: with tr_b=1 latched at start, ACCUM SHALL drive mcand=B[j][k].
REQ-035 Macro MATSEQ_TRANSPOSE_EN undefined: the tr_b port exists but is ignored, and mcand=B[k][j] always.

Structure
REQ-036 Package matseq_pkg SHALL hold the default N and DW, the index width localparam, and the FSM state enum.
REQ-037 Sub-module matseq_regfile SHALL hold the A and B stores: one write port, two combinational read ports, synchronous clear.

Verification
REQ-038 A=identity, B[r][c]=4r+c+1, start -> results (0,0)..(3,3) in row-major order; mcand stream for (1,2) is 3,7,11,15; done 97 cycles after start.
REQ-039 res_ready low 5 cycles in EMIT for (0,1) -> res_valid, res_row=0 and res_col=1 held stable; mac_en=0 and mac_clr=0 throughout.
REQ-040 start and wr_en pulsed during ACCUM -> no restart, and stores unchanged (read back after done).
REQ-041 aclr=1 during ACCUM k=2 -> next cycle all outputs 0 and state IDLE; a new start yields mplier=mcand=0 throughout.
REQ-042 MATSEQ_TRANSPOSE_EN defined, B[0][1]=5, others 0, tr_b=1 -> mcand for (0,0) is 0,5,0,0; with tr_b=0 -> mcand for (0,1) is 5,0,0,0.
REQ-043 All elements 255 -> every ACCUM cycle drives mplier=mcand=255, and exactly 16 res_valid handshakes occur.
